// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, sequencer states and multi-cycle op classification for alu_seq
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHR  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MULH = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_REM  = 4'd11;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
  function automatic logic is_multicycle(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider sharing a hi:lo register pair
import alu_pkg::*;
module alu_muldiv_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic             r_busy, r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
  logic [WIDTH:0]   w_sum, w_sh, w_dif;
  logic [WIDTH-1:0] w_nhi, w_nlo;
  // lo/hi expose this cycle's update so the top can register the final iteration directly
  always_comb begin
    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_sh  = {r_hi, r_lo[WIDTH-1]};
    w_dif = w_sh - {1'b0, r_opnd};
    w_nhi = r_div ? (w_dif[WIDTH] ? w_sh[WIDTH-1:0] : w_dif[WIDTH-1:0]) : w_sum[WIDTH:1];
    w_nlo = r_div ? {r_lo[WIDTH-2:0], ~w_dif[WIDTH]} : {w_sum[0], r_lo[WIDTH-1:1]};
  end
  assign done      = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign lo        = w_nlo;
  assign hi        = w_nhi;
  assign quotient  = w_nlo;
  assign remainder = w_nhi;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_div  <= (op == OP_DIV) || (op == OP_REM);
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= ((op == OP_DIV) || (op == OP_REM)) ? a : b;
      r_opnd <= ((op == OP_DIV) || (op == OP_REM)) ? b : a;
    end else if (r_busy) begin
      r_hi   <= w_nhi;
      r_lo   <= w_nlo;
      r_cnt  <= r_cnt + 1'b1;
      r_busy <= !done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/arith ops and iterative MUL/MULH/DIV/REM behind valid/ready
import alu_pkg::*;
module alu_seq #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_dz,
  output logic             flag_ill
);
  state_t           r_state, w_state_nx;
  logic [3:0]       r_op;
  logic             w_accept, w_is_div, w_start, w_done;
  logic [WIDTH-1:0] w_lo, w_hi, w_quo, w_rem, w_mres, w_res;
  logic [WIDTH:0]   w_sum, w_dif;
  logic             w_c, w_v, w_dz, w_ill;
  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_is_div = (op_code == OP_DIV) || (op_code == OP_REM);
  // divide by zero skips iteration and reports like a single-cycle op
  assign w_start  = w_accept && is_multicycle(op_code) && !(w_is_div && (b == '0));
  alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk(clk), .rst_n(rst_n), .start(w_start), .op(op_code), .a(a), .b(b),
    .done(w_done), .lo(w_lo), .hi(w_hi), .quotient(w_quo), .remainder(w_rem)
  );
  always_comb begin
    w_state_nx = r_state;
    if (r_state == ST_IDLE)
      w_state_nx = w_start ? (w_is_div ? ST_DIV : ST_MUL) : ST_IDLE;
    else if (w_done)
      w_state_nx = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_start) r_op <= op_code;
    end
  end
  always_comb begin
    w_sum = {1'b0, a} + {1'b0, b};
    w_dif = {1'b0, a} - {1'b0, b};
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_dz  = 1'b0;
    w_ill = 1'b0;
    case (op_code)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHR: begin w_res = a >> 1; w_c = a[0]; end
      OP_SHL: begin w_res = a << 1; w_c = a[WIDTH-1]; end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_NOT: w_res = ~a;
      OP_XOR: w_res = a ^ b;
      OP_MUL, OP_MULH: w_res = '0;
      OP_DIV: begin w_res = '1; w_dz = 1'b1; end
      OP_REM: begin w_res = a; w_dz = 1'b1; end
      default: w_ill = 1'b1;
    endcase
    w_mres = (r_op == OP_MUL) ? w_lo : (r_op == OP_MULH) ? w_hi : (r_op == OP_DIV) ? w_quo : w_rem;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      flag_dz   <= 1'b0;
      flag_ill  <= 1'b0;
    end else if (w_done) begin
      out_valid <= 1'b1;
      result    <= w_mres;
      flag_c    <= 1'b0;
      flag_z    <= (w_mres == '0);
      flag_n    <= w_mres[WIDTH-1];
      flag_v    <= 1'b0;
      flag_dz   <= 1'b0;
      flag_ill  <= 1'b0;
    end else if (w_accept && !w_start) begin
      out_valid <= 1'b1;
      result    <= w_res;
      flag_c    <= w_c;
      flag_z    <= (w_res == '0);
      flag_n    <= w_res[WIDTH-1];
      flag_v    <= w_v;
      flag_dz   <= w_dz;
      flag_ill  <= w_ill;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule
